io_poll_master: RTL and testbench

Autonomous initiator for the memory-mapped IO port map, standing in for the CPU's load/store path. It periodically reads the two switch input ports, computes a selectable operation on the operands, and writes the left operand, right operand and result to the three seven-segment output ports. It sits where the pipeline's memory-stage IO bus attaches, and drives the IO block's `addr` / `datain` / `write_io_enable` while consuming its `io_read_dataout`. This lets the IO block be exercised on the board without a running program.

---
 rtl/io_poll_master_pkg.sv | 33 +++
 rtl/io_poll_alu.sv | 35 +++
 rtl/io_poll_master.sv | 126 ++++++++++++
 tb/tb_io_poll_master.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/io_poll_master_pkg.sv
// Shared definitions for the IO port-map poller: port addresses, operation codes,
// sequencer states and the bus request record.
package io_poll_master_pkg;

   localparam logic [31:0] ADDR_IN0       = 32'h0000_00C0;
   localparam logic [31:0] ADDR_IN1       = 32'h0000_00C4;
   localparam logic [31:0] ADDR_OUT_RES   = 32'h0000_0080;
   localparam logic [31:0] ADDR_OUT_RIGHT = 32'h0000_0084;
   localparam logic [31:0] ADDR_OUT_LEFT  = 32'h0000_0088;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_MUL = 2'b10,
      OP_MAX = 2'b11
   } op_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD0,
      ST_RD1,
      ST_WR_L,
      ST_WR_R,
      ST_WR_RES
   } state_e;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
      logic        we;
   } io_req_t;

endpackage

// File: rtl/io_poll_alu.sv
// Combinational operand ALU: add / saturating subtract / multiply / max on 10-bit
// zero-extended operands, clamped to RESULT_MAX.
module io_poll_alu
   import io_poll_master_pkg::*;
#(
   parameter int RESULT_MAX = 99
) (
   input  logic [4:0]  a,
   input  logic [4:0]  b,
   input  logic [1:0]  op_q,
   output logic [31:0] r
);

   localparam logic [31:0] RMAX = 32'(RESULT_MAX);

   logic [9:0]  a10;
   logic [9:0]  b10;
   logic [9:0]  res;
   logic [31:0] res32;

   always_comb begin
      a10 = {5'b0, a};
      b10 = {5'b0, b};
      res = '0;
      case (op_e'(op_q))
         OP_ADD:  res = a10 + b10;
         OP_SUB:  res = (a10 >= b10) ? (a10 - b10) : '0;
         OP_MUL:  res = a10 * b10;
         default: res = (a10 > b10) ? a10 : b10;
      endcase
      res32 = {22'b0, res};
      r = (res32 > RMAX) ? RMAX : res32;
   end

endmodule

// File: rtl/io_poll_master.sv
// Autonomous IO bus initiator: every PERIOD idle cycles reads both switch ports,
// then writes left, right and the ALU result to the display ports.
module io_poll_master
   import io_poll_master_pkg::*;
#(
   parameter int PERIOD     = 50_000_000,
   parameter int RESULT_MAX = 99
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        enable,
   input  logic [1:0]  op_sel,
   input  logic [31:0] io_read_data,
   output logic [31:0] addr,
   output logic [31:0] dataout,
   output logic        write_io_enable,
   output logic        busy,
   output logic        done
);

   localparam int            CW       = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(PERIOD - 1);

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [4:0]    a_q, b_q;
   logic [1:0]    op_q;
   logic [31:0]   r;
   io_req_t       bus_d;
   logic          busy_d;
   logic          done_d;
   logic          unused_rd;

   // Only the low five switch bits carry an operand.
   assign unused_rd = ^io_read_data[31:5];

   io_poll_alu #(
      .RESULT_MAX(RESULT_MAX)
   ) u_alu (
      .a    (a_q),
      .b    (b_q),
      .op_q (op_q),
      .r    (r)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bus_d   = '0;
      case (state_q)
         ST_IDLE: begin
            // Counter parks at its last value until enable lets the sequence start.
            if (cnt_q == CNT_LAST) begin
               if (enable) state_d = ST_RD0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_RD0:    state_d = ST_RD1;
         ST_RD1:    state_d = ST_WR_L;
         ST_WR_L:   state_d = ST_WR_R;
         ST_WR_R:   state_d = ST_WR_RES;
         ST_WR_RES: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase

      // Outputs are decoded from the next state so they register alongside it.
      case (state_d)
         ST_RD0: bus_d.addr = ADDR_IN0;
         ST_RD1: bus_d.addr = ADDR_IN1;
         ST_WR_L: begin
            bus_d.addr = ADDR_OUT_LEFT;
            bus_d.data = {27'b0, a_q};
            bus_d.we   = 1'b1;
         end
         ST_WR_R: begin
            bus_d.addr = ADDR_OUT_RIGHT;
            bus_d.data = {27'b0, b_q};
            bus_d.we   = 1'b1;
         end
         ST_WR_RES: begin
            bus_d.addr = ADDR_OUT_RES;
            bus_d.data = r;
            bus_d.we   = 1'b1;
         end
         default: bus_d = '0;
      endcase
      busy_d = (state_d != ST_IDLE);
      done_d = (state_q == ST_WR_RES);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q         <= ST_IDLE;
         cnt_q           <= '0;
         a_q             <= '0;
         b_q             <= '0;
         op_q            <= '0;
         addr            <= '0;
         dataout         <= '0;
         write_io_enable <= 1'b0;
         busy            <= 1'b0;
         done            <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (state_q == ST_RD0) begin
            a_q  <= io_read_data[4:0];
            op_q <= op_sel;
         end
         if (state_q == ST_RD1) b_q <= io_read_data[4:0];
         addr            <= bus_d.addr;
         dataout         <= bus_d.data;
         write_io_enable <= bus_d.we;
         busy            <= busy_d;
         done            <= done_d;
      end
   end

endmodule

// File: tb/tb_io_poll_master.sv
// Randomized bench for io_poll_master: a spec-level bus predictor plus a write
// scoreboard fed with expected port writes whenever operands are served.
module tb_io_poll_master;

   localparam int PERIOD = 4;
   localparam int RMAX   = 99;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b1;
   logic [1:0]  op_sel = 2'b00;
   logic [31:0] io_read_data;
   logic [31:0] addr, dataout;
   logic        write_io_enable, busy, done;

   logic [4:0]  sw_a = 5'd0, sw_b = 5'd0;
   logic [31:0] junk = 32'h0;
   logic        rst_s = 1'b1, en_s = 1'b0;
   int          n_cmp = 0, n_err = 0, cyc = 0;

   typedef struct {
      logic [31:0] a;
      logic [31:0] d;
      int          c;
   } wr_t;
   wr_t expq[$];
   wr_t e_b;

   always #5 clock = ~clock;

   io_poll_master #(.PERIOD(PERIOD), .RESULT_MAX(RMAX)) dut (
      .clock           (clock),
      .reset           (reset),
      .enable          (enable),
      .op_sel          (op_sel),
      .io_read_data    (io_read_data),
      .addr            (addr),
      .dataout         (dataout),
      .write_io_enable (write_io_enable),
      .busy            (busy),
      .done            (done)
   );

   // IO block read mux: switches on the two input ports, noise elsewhere.
   assign io_read_data = (addr == 32'hC0) ? {junk[31:5], sw_a} :
                         (addr == 32'hC4) ? {junk[31:5], sw_b} : junk;

   always @(posedge clock) begin
      cyc   <= cyc + 1;
      rst_s <= reset;
      en_s  <= enable;
   end

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at cycle %0d", nm, act, exp, cyc);
      end
   endtask

   function automatic int model_r(int a, int b, int op);
      int r;
      case (op)
         0:       r = a + b;
         1:       r = (a >= b) ? a - b : 0;
         2:       r = a * b;
         default: r = (a > b) ? a : b;
      endcase
      return (r > RMAX) ? RMAX : r;
   endfunction

   // Predictor: pos 0 idle, 1..5 = RD0, RD1, WR_L, WR_R, WR_RES.
   int          pos = 0, since = 0, idle_start = 0, ea = 0, eb = 0, eop = 0;
   bit          edone;
   logic [31:0] exp_addr;

   always @(negedge clock) begin
      if (rst_s) begin
         chk("rst_addr", addr, 32'h0);
         chk("rst_data", dataout, 32'h0);
         chk("rst_we",   32'(write_io_enable), 32'h0);
         chk("rst_busy", 32'(busy), 32'h0);
         chk("rst_done", 32'(done), 32'h0);
         pos = 0; since = 0; idle_start = 0;
      end else begin
         since++;
         edone = (pos == 5);
         if (pos == 5) begin
            pos = 0;
            idle_start = since;
         end else if (pos != 0) begin
            pos++;
         end else if (since >= idle_start + PERIOD && en_s) begin
            pos = 1;
         end
         case (pos)
            1:       exp_addr = 32'hC0;
            2:       exp_addr = 32'hC4;
            3:       exp_addr = 32'h88;
            4:       exp_addr = 32'h84;
            5:       exp_addr = 32'h80;
            default: exp_addr = 32'h0;
         endcase
         chk("addr", addr, exp_addr);
         chk("we",   32'(write_io_enable), (pos >= 3) ? 32'd1 : 32'd0);
         chk("busy", 32'(busy), (pos != 0) ? 32'd1 : 32'd0);
         chk("done", 32'(done), edone ? 32'd1 : 32'd0);
         if (pos == 1) begin
            ea  = int'(sw_a);
            eop = int'(op_sel);
         end
         if (pos == 2) begin
            eb = int'(sw_b);
            expq.push_back('{32'h88, 32'(ea), cyc + 1});
            expq.push_back('{32'h84, 32'(eb), cyc + 2});
            expq.push_back('{32'h80, 32'(model_r(ea, eb, eop)), cyc + 3});
         end
      end
   end

   // Write monitor.
   always @(negedge clock) begin
      if (rst_s) begin
         expq.delete();
      end else if (write_io_enable) begin
         if (expq.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, want no write at cycle %0d",
                     addr, dataout, cyc);
         end else begin
            e_b = expq.pop_front();
            chk("wr_addr",  addr, e_b.a);
            chk("wr_data",  dataout, e_b.d);
            chk("wr_cycle", 32'(cyc), 32'(e_b.c));
         end
      end
   end

   task automatic wait_done(string nm);
      int k = 0;
      do begin
         @(posedge clock); #1; k++;
      end while (!done && k < 80);
      if (!done) begin
         n_cmp++; n_err++;
         $display("FAIL %s_timeout: got no done, want done within 80 cycles", nm);
      end
   endtask

   task automatic wait_bus(string nm, logic [31:0] v);
      int k = 0;
      do begin
         @(posedge clock); #1; k++;
      end while (addr != v && k < 80);
      if (addr != v) begin
         n_cmp++; n_err++;
         $display("FAIL %s_timeout: got addr 0x%0h, want 0x%0h within 80 cycles", nm, addr, v);
      end
   endtask

   task automatic set_ops(logic [4:0] a, logic [4:0] b, logic [1:0] op);
      sw_a = a; sw_b = b; op_sel = op;
   endtask

   initial begin
      junk = $urandom;
      set_ops(5'd7, 5'd12, 2'b00);
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      wait_done("add");

      set_ops(5'd3, 5'd9, 2'b01);   wait_done("sub_under");
      set_ops(5'd31, 5'd0, 2'b01);  wait_done("sub_31");
      set_ops(5'd31, 5'd31, 2'b10); wait_done("mul_clamp");
      set_ops(5'd9, 5'd11, 2'b10);  wait_done("mul_99");

      // enable dropped during WR_L: sequence finishes, then stays quiet
      set_ops(5'd20, 5'd4, 2'b11);
      wait_bus("wr_l", 32'h88);
      enable = 1'b0;
      wait_done("en_drop");
      repeat (25) @(posedge clock);
      #1 enable = 1'b1;
      wait_done("en_back");

      // op_sel change during RD1 must not affect the in-flight result
      set_ops(5'd5, 5'd6, 2'b00);
      wait_bus("rd1", 32'hC4);
      op_sel = 2'b10;
      wait_done("op_latch");

      // reset during WR_R aborts the result write
      set_ops(5'd17, 5'd2, 2'b00);
      wait_bus("wr_r", 32'h84);
      reset = 1'b1;
      @(posedge clock); #1 reset = 1'b0;
      wait_done("post_reset");

      repeat (1000) begin
         @(posedge clock); #1;
         sw_a   = 5'($urandom);
         sw_b   = 5'($urandom);
         op_sel = 2'($urandom);
         junk   = $urandom;
         if ($urandom_range(0, 19) == 0) enable = ~enable;
         reset = ($urandom_range(0, 249) == 0);
      end
      @(posedge clock); #1;
      reset  = 1'b0;
      enable = 1'b1;
      wait_done("final");
      chk("queue_empty", 32'(expq.size()), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
